// File: rtl/fighter_pkg.sv
// Shared fighter definitions: defender state encoding, attack type codes and
// the damage lookup used by the hit receiver.
package fighter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HITSTUN = 2'd1,
    ST_INVULN  = 2'd2,
    ST_KO      = 2'd3
  } hit_state_t;

  localparam logic [1:0] ATK_NONE = 2'd0;
  localparam logic [1:0] ATK1     = 2'd1;

  localparam int unsigned HEALTH_W = 7;
  localparam int unsigned POS_W    = 10;
  localparam int unsigned CNT_W    = 4;

  // Unknown attack codes fall back to ATK1 damage so a glitching opponent still hurts.
  function automatic logic [HEALTH_W-1:0] attack_damage(
    input logic [1:0]          atk_type,
    input logic [HEALTH_W-1:0] atk1_dmg
  );
    case (atk_type)
      ATK_NONE: attack_damage = '0;
      default:  attack_damage = atk1_dmg;
    endcase
  endfunction

  function automatic logic [HEALTH_W-1:0] sat_sub(
    input logic [HEALTH_W-1:0] value,
    input logic [HEALTH_W-1:0] dmg
  );
    sat_sub = (value <= dmg) ? '0 : value - dmg;
  endfunction

endpackage

// File: rtl/hitbox_overlap.sv
// Combinational range check: is self within HIT_RANGE pixels in front of the
// attacker? Ordering is tested before subtracting so the difference never wraps.
module hitbox_overlap
  import fighter_pkg::*;
#(
  parameter int unsigned HIT_RANGE = 40
) (
  input  logic [POS_W-1:0] opp_x,
  input  logic             opp_facing,
  input  logic [POS_W-1:0] self_x,
  output logic             in_range
);

  logic [POS_W-1:0] diff;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    in_range = 1'b0;
    diff     = '0;
    if (opp_facing) begin
      if (self_x >= opp_x) begin
        diff     = self_x - opp_x;
        in_range = (diff <= POS_W'(HIT_RANGE));
      end
    end else begin
      if (opp_x >= self_x) begin
        diff     = opp_x - self_x;
        in_range = (diff <= POS_W'(HIT_RANGE));
      end
    end
  end

endmodule

// File: rtl/player_hit_receiver.sv
// Defender-side hit logic: lands at most one hit per opponent attack window,
// applies damage, and sequences hitstun -> invulnerability -> idle, or KO.
// Optional chip-damage blocking is enabled by defining PLAYER_BLOCK_EN.
module player_hit_receiver
  import fighter_pkg::*;
#(
  parameter int unsigned HEALTH_MAX     = 100,
  parameter int unsigned HIT_RANGE      = 40,
  parameter int unsigned ATK1_DAMAGE    = 10,
  parameter int unsigned CHIP_DAMAGE    = 2,
  parameter int unsigned HITSTUN_FRAMES = 12,
  parameter int unsigned INVULN_FRAMES  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                SCEN,
  input  logic                opp_attack_active,
  input  logic [1:0]          opp_attack_type,
  input  logic [POS_W-1:0]    opp_x,
  input  logic                opp_facing,
  input  logic [POS_W-1:0]    self_x,
  input  logic                block,
  output logic [HEALTH_W-1:0] health,
  output logic                hit_pulse,
  output logic                hit_stun,
  output logic [3:0]          hurt_frame,
  output logic                knock_dir,
  output logic                invuln,
  output logic                ko
);

  hit_state_t          state, next_state;
  logic [CNT_W-1:0]    cnt, next_cnt;
  logic [HEALTH_W-1:0] next_health;
  logic                consumed, next_consumed;
  logic                next_knock_dir;
  logic                hit;
  logic                in_range;
  logic                blocked;
  logic [HEALTH_W-1:0] dmg;
  logic [HEALTH_W-1:0] hit_health;

  hitbox_overlap #(.HIT_RANGE(HIT_RANGE)) u_overlap (
    .opp_x      (opp_x),
    .opp_facing (opp_facing),
    .self_x     (self_x),
    .in_range   (in_range)
  );

`ifdef PLAYER_BLOCK_EN
  assign blocked = block;
`else
  logic unused_block;
  assign unused_block = block;
  assign blocked      = 1'b0;
`endif

  assign dmg        = blocked ? HEALTH_W'(CHIP_DAMAGE)
                              : attack_damage(opp_attack_type, HEALTH_W'(ATK1_DAMAGE));
  assign hit_health = sat_sub(health, dmg);

  always_comb begin
    next_state     = state;
    next_cnt       = cnt;
    next_health    = health;
    next_consumed  = consumed;
    next_knock_dir = knock_dir;
    hit            = 1'b0;

    if (SCEN && state != ST_KO) begin
      if (!opp_attack_active) next_consumed = 1'b0;

      case (state)
        ST_IDLE: begin
          if (!consumed && opp_attack_active && opp_attack_type != ATK_NONE && in_range) begin
            hit            = 1'b1;
            next_consumed  = 1'b1;
            next_knock_dir = opp_facing;
            next_health    = hit_health;
            next_cnt       = '0;
            if (hit_health == '0) next_state = ST_KO;
            else if (!blocked)    next_state = ST_HITSTUN;
          end
        end
        ST_HITSTUN: begin
          if (cnt == CNT_W'(HITSTUN_FRAMES - 1)) begin
            next_state = ST_INVULN;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
        ST_INVULN: begin
          if (cnt == CNT_W'(INVULN_FRAMES - 1)) begin
            next_state = ST_IDLE;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      health    <= HEALTH_W'(HEALTH_MAX);
      consumed  <= 1'b0;
      knock_dir <= 1'b0;
      hit_pulse <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      health    <= next_health;
      consumed  <= next_consumed;
      knock_dir <= next_knock_dir;
      hit_pulse <= hit;
    end
  end

  assign hit_stun   = (state == ST_HITSTUN);
  assign hurt_frame = hit_stun ? 4'(cnt) : 4'd0;
  assign invuln     = (state == ST_INVULN);
  assign ko         = (state == ST_KO);

endmodule
